// File: rtl/tetris_pkg.sv
// Shared board geometry, empty-cell colour and line-clear state encoding
// used by every board RAM client.
package tetris_pkg;

   localparam int         BOARD_W      = 10;
   localparam int         BOARD_H      = 20;
   localparam logic [5:0] COLOUR_EMPTY = 6'd0;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SCAN_CHK,
      SHIFT_RD,
      SHIFT_WR,
      CLEAR_TOP,
      DONE
   } lc_state_e;

endpackage

// File: rtl/board_addr.sv
// Combinational board RAM address: row*BOARD_W+col, 8-bit unsigned.
module board_addr
   import tetris_pkg::*;
(
   input  logic [4:0] row_i,
   input  logic [3:0] col_i,
   output logic [7:0] addr_o
);

   assign addr_o = 8'(row_i) * 8'(BOARD_W) + 8'(col_i);

endmodule

// File: rtl/line_clear.sv
// Finds full board rows bottom-up, shifts everything above down one row and
// empties row 0. Optional lines_total counter under LINE_CLEAR_TOTAL_EN.
module line_clear
   import tetris_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [5:0]  ram_Q,
   output logic [7:0]  ram_addr,
   output logic [5:0]  ram_data,
   output logic        ram_wren,
   output logic [4:0]  rows_cleared,
   output logic        complete
`ifdef LINE_CLEAR_TOTAL_EN
   ,
   output logic [15:0] lines_total
`endif
);

   localparam logic [3:0] COL_LAST = 4'(BOARD_W - 1);
   localparam logic [4:0] ROW_TOP  = 5'(BOARD_H - 1);

   lc_state_e  state_q, state_d;
   logic [4:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic [4:0] dst_q, dst_d;
   logic [4:0] count_q, count_d;
   logic       full_q, full_d;
   logic [4:0] rows_cleared_q, rows_cleared_d;
   logic       complete_q, complete_d;
   logic [4:0] addr_row;
   logic       occupied;
   logic       row_full;

   assign occupied = (ram_Q != COLOUR_EMPTY);
   // The word for the last column arrives during SCAN_CHK itself.
   assign row_full = full_q & occupied;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         row_q          <= '0;
         col_q          <= '0;
         dst_q          <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         rows_cleared_q <= '0;
         complete_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         dst_q          <= dst_d;
         count_q        <= count_d;
         full_q         <= full_d;
         rows_cleared_q <= rows_cleared_d;
         complete_q     <= complete_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      col_d          = col_q;
      dst_d          = dst_q;
      count_d        = count_q;
      full_d         = full_q;
      rows_cleared_d = rows_cleared_q;
      complete_d     = 1'b0;
      ram_wren       = 1'b0;
      ram_data       = COLOUR_EMPTY;
      case (state_q)
         IDLE: begin
            if (enable) begin
               row_d   = ROW_TOP;
               col_d   = '0;
               count_d = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            full_d = (col_q == '0) ? 1'b1 : (full_q & occupied);
            if (col_q == COL_LAST) begin
               col_d   = '0;
               state_d = SCAN_CHK;
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         SCAN_CHK: begin
            if (row_full) begin
               count_d = count_q + 5'd1;
               dst_d   = row_q;
               col_d   = '0;
               state_d = (row_q == '0) ? CLEAR_TOP : SHIFT_RD;
            end else if (row_q == '0) begin
               rows_cleared_d = count_q;
               complete_d     = 1'b1;
               state_d        = DONE;
            end else begin
               row_d   = row_q - 5'd1;
               state_d = SCAN;
            end
         end
         SHIFT_RD: state_d = SHIFT_WR;
         SHIFT_WR: begin
            ram_wren = 1'b1;
            ram_data = ram_Q;
            if (col_q == COL_LAST) begin
               col_d   = '0;
               dst_d   = dst_q - 5'd1;
               state_d = (dst_q == 5'd1) ? CLEAR_TOP : SHIFT_RD;
            end else begin
               col_d   = col_q + 4'd1;
               state_d = SHIFT_RD;
            end
         end
         CLEAR_TOP: begin
            ram_wren = 1'b1;
            if (col_q == COL_LAST) begin
               // Re-scan the same row: the row shifted into it may be full too.
               col_d   = '0;
               state_d = SCAN;
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         DONE: begin
            if (!enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!enable && state_q != IDLE && state_q != DONE) begin
         state_d        = IDLE;
         ram_wren       = 1'b0;
         complete_d     = 1'b0;
         rows_cleared_d = rows_cleared_q;
      end
   end

   always_comb begin
      addr_row = row_q;
      case (state_q)
         SHIFT_RD:  addr_row = dst_q - 5'd1;
         SHIFT_WR:  addr_row = dst_q;
         CLEAR_TOP: addr_row = '0;
         default:   addr_row = row_q;
      endcase
   end

   board_addr u_board_addr (
      .row_i  (addr_row),
      .col_i  (col_q),
      .addr_o (ram_addr)
   );

   assign rows_cleared = rows_cleared_q;
   assign complete     = complete_q;

`ifdef LINE_CLEAR_TOTAL_EN
   logic [15:0] lines_total_q;
   logic [16:0] total_sum;

   assign total_sum = {1'b0, lines_total_q} + {12'd0, count_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lines_total_q <= '0;
      end else if (complete_d) begin
         lines_total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
   end

   assign lines_total = lines_total_q;
`endif

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: board RAM model plus a row-compaction
// reference model; covers lines_total when LINE_CLEAR_TOTAL_EN is defined.
module tb_line_clear;

   localparam int W = 10;
   localparam int H = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [5:0]  ram_Q = 6'd0;
   logic [7:0]  ram_addr;
   logic [5:0]  ram_data;
   logic        ram_wren;
   logic [4:0]  rows_cleared;
   logic        complete;
`ifdef LINE_CLEAR_TOTAL_EN
   logic [15:0] lines_total;
`endif

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;
   int exp_cleared;
   int last_rows = 0;

   logic [5:0] mem   [0:255];
   logic [5:0] board [0:H-1][0:W-1];
   logic [5:0] exp_b [0:H-1][0:W-1];

   line_clear dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .ram_Q        (ram_Q),
      .ram_addr     (ram_addr),
      .ram_data     (ram_data),
      .ram_wren     (ram_wren),
      .rows_cleared (rows_cleared),
      .complete     (complete)
`ifdef LINE_CLEAR_TOTAL_EN
      ,
      .lines_total  (lines_total)
`endif
   );

   always #5 clk = ~clk;

   // Board RAM: registered read, old data on read-during-write.
   always @(posedge clk) begin
      ram_Q <= mem[ram_addr];
      if (ram_wren === 1'b1) begin
         mem[ram_addr] = ram_data;
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_board();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            board[r][c] = 6'd0;
   endtask

   task automatic load_board();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            mem[r*W+c] = board[r][c];
   endtask

   // Reference: keep non-full rows in order, bottom-aligned; empty rows on top.
   task automatic model();
      int  k;
      bit  full;
      k = H - 1;
      exp_cleared = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            exp_b[r][c] = 6'd0;
      for (int r = H - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < W; c++)
            if (board[r][c] == 6'd0) full = 1'b0;
         if (full) begin
            exp_cleared++;
         end else begin
            for (int c = 0; c < W; c++) exp_b[k][c] = board[r][c];
            k--;
         end
      end
   endtask

   task automatic check_board(input string name);
      int bad, fr, fc;
      logic [5:0] got, want;
      bad = 0; fr = 0; fc = 0; got = 6'd0; want = 6'd0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (mem[r*W+c] !== exp_b[r][c]) begin
               if (bad == 0) begin
                  fr = r; fc = c; got = mem[r*W+c]; want = exp_b[r][c];
               end
               bad++;
            end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s_board: %0d cells differ, first (%0d,%0d)=%0d required %0d",
                  name, bad, fr, fc, got, want);
      end
   endtask

   task automatic make_stack(input int n);
      clear_board();
      for (int r = H - n; r < H; r++)
         for (int c = 0; c < W; c++)
            board[r][c] = 6'd4;
      board[H-n-1][2] = 6'd6;
   endtask

   task automatic run_pass(input string name, output int lat, output int wrs, output bit ok);
      int start_w, n, extra;
      @(negedge clk);
      enable  = 1'b1;
      start_w = wr_cnt;
      @(posedge clk);
      lat = 0; ok = 1'b0; n = 0;
      while (!ok && n < 8000) begin
         @(negedge clk);
         if (complete === 1'b1) ok = 1'b1;
         else lat++;
         n++;
      end
      wrs = wr_cnt - start_w;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_timeout: complete=0 after %0d cycles, required a pulse", name, n);
      end
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (complete !== 1'b0 || ram_wren !== 1'b0) extra++;
      end
      tests++;
      if (extra != 0) begin
         fails++;
         $display("FAIL %s_hold: %0d cycles with complete/ram_wren high while held, required 0", name, extra);
      end
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_pass(input string name);
      int lat, wrs;
      bit ok;
      load_board();
      model();
      run_pass(name, lat, wrs, ok);
      tests++;
      if (rows_cleared !== 5'(exp_cleared)) begin
         fails++;
         $display("FAIL %s_rows: rows_cleared=%0d required %0d", name, rows_cleared, exp_cleared);
      end
      check_board(name);
      last_rows = exp_cleared;
      $display("[TB] pass %s: cleared %0d, latency %0d, writes %0d", name, exp_cleared, lat, wrs);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (ram_addr !== 8'd0 || ram_data !== 6'd0 || ram_wren !== 1'b0 ||
          rows_cleared !== 5'd0 || complete !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: addr=%0d data=%0d wren=%b rows=%0d complete=%b required all 0",
                  ram_addr, ram_data, ram_wren, rows_cleared, complete);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset checked");
   endtask

   task automatic test_empty();
      int lat, wrs;
      bit ok;
      clear_board();
      load_board();
      model();
      run_pass("empty", lat, wrs, ok);
      tests++;
      if (lat != 220) begin
         fails++;
         $display("FAIL empty_latency: %0d cycles required 220", lat);
      end
      tests++;
      if (rows_cleared !== 5'd0) begin
         fails++;
         $display("FAIL empty_rows: rows_cleared=%0d required 0", rows_cleared);
      end
      tests++;
      if (wrs != 0) begin
         fails++;
         $display("FAIL empty_writes: %0d ram_wren pulses required 0", wrs);
      end
      check_board("empty");
      last_rows = 0;
      $display("[TB] pass empty: latency %0d, writes %0d", lat, wrs);
   endtask

   task automatic test_single_row();
      clear_board();
      for (int c = 0; c < W; c++) board[19][c] = 6'd5;
      board[18][3] = 6'd2;
      do_pass("single_row");
      tests++;
      if (mem[193] !== 6'd2 || mem[190] !== 6'd0) begin
         fails++;
         $display("FAIL single_row_cells: (19,3)=%0d (19,0)=%0d required 2 and 0", mem[193], mem[190]);
      end
   endtask

   task automatic test_two_rows();
      clear_board();
      for (int c = 0; c < W; c++) begin
         board[18][c] = 6'd5;
         board[19][c] = 6'd5;
      end
      board[17][0] = 6'd7;
      do_pass("two_rows");
      tests++;
      if (mem[190] !== 6'd7) begin
         fails++;
         $display("FAIL two_rows_cell: (19,0)=%0d required 7", mem[190]);
      end
   endtask

   task automatic test_top_row();
      clear_board();
      for (int c = 0; c < W; c++) board[0][c] = 6'd3;
      board[5][4]  = 6'd9;
      board[19][0] = 6'd1;
      board[19][9] = 6'd2;
      do_pass("top_row");
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         clear_board();
         for (int r = 0; r < H; r++) begin
            if ($urandom_range(0, 2) == 0) begin
               for (int c = 0; c < W; c++) board[r][c] = 6'($urandom_range(1, 63));
            end else begin
               for (int c = 0; c < W; c++)
                  board[r][c] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
               board[r][$urandom_range(0, W - 1)] = 6'd0;
            end
         end
         do_pass($sformatf("random%0d", t));
      end
   endtask

   task automatic test_abort();
      int seen, n, extra;
      clear_board();
      for (int c = 0; c < W; c++) begin
         board[19][c] = 6'd9;
         board[18][c] = (c == W - 1) ? 6'd0 : 6'($urandom_range(1, 63));
      end
      load_board();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            exp_b[r][c] = board[r][c];
      for (int c = 0; c < 4; c++) exp_b[19][c] = board[18][c];
      @(negedge clk);
      enable = 1'b1;
      seen = 0; n = 0;
      while (seen < 5 && n < 2000) begin
         @(negedge clk);
         if (ram_wren === 1'b1) seen++;
         n++;
      end
      tests++;
      if (seen < 5) begin
         fails++;
         $display("FAIL abort_reach: %0d writes seen, required 5", seen);
      end
      enable = 1'b0;
      #1;
      tests++;
      if (ram_wren !== 1'b0) begin
         fails++;
         $display("FAIL abort_wren: ram_wren=%b in abort cycle required 0", ram_wren);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (complete !== 1'b0 || ram_wren !== 1'b0 || rows_cleared !== 5'(last_rows)) begin
         fails++;
         $display("FAIL abort_next: complete=%b wren=%b rows=%0d required 0 0 %0d",
                  complete, ram_wren, rows_cleared, last_rows);
      end
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (complete !== 1'b0 || ram_wren !== 1'b0) extra++;
      end
      tests++;
      if (extra != 0) begin
         fails++;
         $display("FAIL abort_idle: %0d active cycles after abort required 0", extra);
      end
      check_board("abort");
      $display("[TB] abort after %0d writes, rows_cleared %0d", seen, rows_cleared);
   endtask

`ifdef LINE_CLEAR_TOTAL_EN
   task automatic test_total();
      int exp_total;
      int plan [3] = '{1, 4, 2};
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_rows = 0;
      exp_total = 0;
      for (int i = 0; i < 3; i++) begin
         make_stack(plan[i]);
         do_pass($sformatf("total%0d", i));
         exp_total += plan[i];
      end
      tests++;
      if (lines_total !== 16'(exp_total)) begin
         fails++;
         $display("FAIL total_sum: lines_total=%0d required %0d", lines_total, exp_total);
      end
      force dut.lines_total_q = 16'hFFFE;
      @(negedge clk);
      release dut.lines_total_q;
      make_stack(2);
      do_pass("total_sat");
      tests++;
      if (lines_total !== 16'hFFFF) begin
         fails++;
         $display("FAIL total_sat: lines_total=%h required ffff", lines_total);
      end
   endtask
`endif

   task automatic test_async_reset();
      int n;
      make_stack(3);
      load_board();
      @(negedge clk);
      enable = 1'b1;
      n = 0;
      while (ram_wren !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (ram_addr !== 8'd0 || ram_data !== 6'd0 || ram_wren !== 1'b0 ||
          rows_cleared !== 5'd0 || complete !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: addr=%0d data=%0d wren=%b rows=%0d complete=%b required all 0",
                  ram_addr, ram_data, ram_wren, rows_cleared, complete);
      end
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      last_rows = 0;
      make_stack(1);
      do_pass("post_reset");
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single_row();
      test_two_rows();
      test_top_row();
      test_random();
      test_abort();
`ifdef LINE_CLEAR_TOTAL_EN
      test_total();
`endif
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock, with all state updated on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port enable, input, 1, a level select from control; the block runs while it is high.
REQ-004 SHALL have port ram_Q, input, 6, board RAM read data, valid one cycle after its address.
REQ-005 SHALL have port ram_addr, output, 8, board RAM address, computed as row*BOARD_W+col.
REQ-006 SHALL have port ram_data, output, 6, board RAM write data.
REQ-007 SHALL have port ram_wren, output, 1, board RAM write enable.
REQ-008 SHALL have port rows_cleared, output, 5, the number of full rows removed in the last completed pass.
REQ-009 SHALL have port complete, output, 1, a one-cycle pulse when a pass ends.

Function
REQ-010 SHALL use the states IDLE, SCAN, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR_TOP and DONE.
REQ-011 SHALL, in IDLE with enable=1, set row=BOARD_H-1, col=0, count=0, and go to SCAN.
REQ-012 SHALL treat a cell as empty when ram_Q==COLOUR_EMPTY (0) and as occupied otherwise.
REQ-013 SHALL, in SCAN, issue (row,col) for col 0..BOARD_W-1 on consecutive cycles.
- full flag: initialised to 1, ANDed with occupancy of each returned word one cycle later.
- Row scan: BOARD_W+1 cycles including SCAN_CHK.
REQ-014 SHALL, in SCAN_CHK with the row not full and row==0, go to DONE; with the row not full and row>0, decrement row and return to SCAN.
REQ-015 SHALL, in SCAN_CHK with the row full, increment count, set dst=row, col=0, and go to SHIFT_RD; if row==0, go to CLEAR_TOP instead.
REQ-016 SHALL, in SHIFT_RD, drive ram_addr=(dst-1,col) with ram_wren=0.
REQ-017 SHALL, in SHIFT_WR, drive ram_addr=(dst,col), ram_data=ram_Q and ram_wren=1.
- Each cell copy takes 2 cycles.
- After col BOARD_W-1: decrement dst and reset col; when dst reaches 0, go to CLEAR_TOP.
REQ-018 SHALL, in CLEAR_TOP, write COLOUR_EMPTY to (0,col) for col 0..BOARD_W-1, one per cycle.
- Then rescan the same row index (col=0) in SCAN, since a shifted-in row may itself be full.
REQ-019 SHALL, in DONE, latch count into rows_cleared and assert complete for exactly one cycle.
- Then hold in DONE, complete=0, until enable=0, then go to IDLE; no restart while enable stays high.
REQ-020 SHALL abort on enable=0 in any state other than IDLE or DONE.
- Next state IDLE; ram_wren=0 that cycle; no complete pulse; rows_cleared unchanged.
REQ-021 SHALL drive ram_wren=0 in every state except SHIFT_WR and CLEAR_TOP.
REQ-022 SHALL keep count 5 bits wide (maximum BOARD_H=20) without overflow; all address arithmetic is 8-bit unsigned.
REQ-023 SHALL report 0 for an empty board after BOARD_H*(BOARD_W+1)=220 cycles from IDLE exit to the complete pulse.

Reset
REQ-024 SHALL, on reset=1, immediately force state=IDLE, ram_addr=0, ram_data=0, ram_wren=0, rows_cleared=0, complete=0, and row/col/dst/count=0.
REQ-025 SHALL, on reset asserted mid-pass, leave RAM partially shifted; no recovery is required beyond returning to IDLE.

Configuration
REQ-026 SHALL, with LINE_CLEAR_TOTAL_EN defined, add output lines_total (16 bits).
- Adds rows_cleared on each complete pulse, saturating at 16'hFFFF.
- Cleared only by reset.
REQ-027 SHALL, without LINE_CLEAR_TOTAL_EN, omit the lines_total port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL take BOARD_W=10, BOARD_H=20, COLOUR_EMPTY=6'd0 and the state encoding from the shared package tetris_pkg.
REQ-029 SHALL compute ram_addr in one combinational sub-module board_addr (row, col -> 8-bit address), shared with other board RAM clients.

Verification
REQ-030 SHALL verify the empty board: enable held -> complete after 220 cycles, rows_cleared=0, no ram_wren pulses.
REQ-031 SHALL verify a single full bottom row: row 19 all 6'd5, row 18 col 3 = 6'd2 -> rows_cleared=1, (19,3)=2, the rest of row 19 = 0, row 0 all 0.
REQ-032 SHALL verify rows 18 and 19 full with row 17 = 6'd7 at col 0 only -> rows_cleared=2, (19,0)=7, rows 0-18 empty.
REQ-033 SHALL verify a full row 0 only -> rows_cleared=1, row 0 cleared, rows 1-19 unchanged.
REQ-034 SHALL verify an abort: enable dropped in the 5th SHIFT_WR cycle -> next cycle state=IDLE, ram_wren=0, no complete, rows_cleared holds its prior value.
REQ-035 SHALL verify LINE_CLEAR_TOTAL_EN: three passes clearing 1, 4 and 2 rows -> lines_total=7; preset to 16'hFFFE, a 2-row pass -> 16'hFFFF.
